fir_mac_engine: RTL and testbench

- Parametrised, time-multiplexed multi-channel FIR filter core.
- Successor to the single-channel fixed-width FIR engine sitting between the I2S2 and SPI front-ends in the top level.
- Adds independent per-channel sample history, a separate coefficient width, a runtime bypass mode, valid/ready handshakes on both sides, and round/saturate output scaling.
- One multiplier-accumulator is shared across all taps; each accepted sample costs NTaps MAC cycles.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_round_sat.sv | 47 ++++
 rtl/fir_mac_engine.sv | 163 ++++++++++++++++
 tb/tb_fir_mac_engine.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the multi-channel FIR MAC engine family.
//   state_t   : engine control states
//   acc_width : accumulator width that cannot overflow over NTaps products
//   ptr_width : tap index / head pointer width
//   ch_width  : channel tag width (at least one bit)
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   function automatic int unsigned acc_width(input int unsigned data_w,
                                             input int unsigned coeff_w,
                                             input int unsigned n_taps);
      return data_w + coeff_w + $clog2(n_taps);
   endfunction

   function automatic int unsigned ptr_width(input int unsigned n_taps);
      return $clog2(n_taps);
   endfunction

   function automatic int unsigned ch_width(input int unsigned n_channels);
      return (n_channels > 1) ? $clog2(n_channels) : 1;
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturation of a wide
// accumulator down to a signed sample.
//   acc    : signed accumulator value
//   result : rounded, shifted and clamped signed sample
module fir_round_sat #(
   parameter int unsigned AccWidth  = 20,
   parameter int unsigned DataWidth = 8,
   parameter int unsigned OutShift  = 0
) (
   input  logic signed [AccWidth-1:0]  acc,
   output logic signed [DataWidth-1:0] result
);

   // One guard bit so the rounding bias can never wrap.
   localparam int unsigned SumWidth = AccWidth + 1;
   localparam logic signed [SumWidth-1:0] MaxVal =
      SumWidth'((64'd1 << (DataWidth - 1)) - 64'd1);
   localparam logic signed [SumWidth-1:0] MinVal = ~MaxVal;

   logic signed [SumWidth-1:0] acc_ext;
   logic signed [SumWidth-1:0] rounded;

   assign acc_ext = {acc[AccWidth-1], acc};

   generate
      if (OutShift > 0) begin : g_round
         localparam logic signed [SumWidth-1:0] Bias =
            SumWidth'(64'd1 << (OutShift - 1));
         logic signed [SumWidth-1:0] biased;
         assign biased  = acc_ext + Bias;
         assign rounded = biased >>> OutShift;
      end else begin : g_pass
         assign rounded = acc_ext;
      end
   endgenerate

   // Clamp to the signed output range.
   always_comb begin
      result = rounded[DataWidth-1:0];
      if (rounded > MaxVal) begin
         result = MaxVal[DataWidth-1:0];
      end else if (rounded < MinVal) begin
         result = MinVal[DataWidth-1:0];
      end
   end

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed multi-channel FIR filter with one shared MAC.
//   clk, resetN                          : clock, synchronous active-low reset
//   coeffWrEn/coeffAddr/coeffData        : coefficient write port (IDLE only)
//   coeffReady                           : coefficient writes accepted
//   clearHistory                         : zero all histories and head pointers
//   bypass                               : pass the accepted sample straight out
//   inValid/inReady/inData/inChannel     : input sample handshake
//   outValid/outReady/outData/outChannel : output sample handshake
module fir_mac_engine
   import fir_pkg::*;
#(
   parameter  int unsigned NTaps      = 13,
   parameter  int unsigned DataWidth  = 8,
   parameter  int unsigned CoeffWidth = 8,
   parameter  int unsigned NChannels  = 2,
   parameter  int unsigned OutShift   = 0,
   localparam int unsigned PtrWidth   = ptr_width(NTaps),
   localparam int unsigned ChWidth    = ch_width(NChannels),
   localparam int unsigned AccWidth   = acc_width(DataWidth, CoeffWidth, NTaps)
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         coeffWrEn,
   input  logic [PtrWidth-1:0]          coeffAddr,
   input  logic signed [CoeffWidth-1:0] coeffData,
   output logic                         coeffReady,
   input  logic                         clearHistory,
   input  logic                         bypass,
   input  logic                         inValid,
   output logic                         inReady,
   input  logic signed [DataWidth-1:0]  inData,
   input  logic [ChWidth-1:0]           inChannel,
   output logic                         outValid,
   input  logic                         outReady,
   output logic signed [DataWidth-1:0]  outData,
   output logic [ChWidth-1:0]           outChannel
);

   localparam int unsigned ProdWidth = DataWidth + CoeffWidth;

   state_t state, state_next;

   logic signed [CoeffWidth-1:0] coeff [NTaps];
   logic signed [DataWidth-1:0]  hist  [NChannels][NTaps];
   logic [PtrWidth-1:0]          head  [NChannels];

   logic [PtrWidth-1:0]          tap;
   logic [ChWidth-1:0]           ch;
   logic signed [AccWidth-1:0]   acc;
   logic signed [AccWidth-1:0]   acc_sum;
   logic signed [ProdWidth-1:0]  prod;
   logic [PtrWidth-1:0]          hist_idx;
   logic [ChWidth-1:0]           in_ch;
   logic                         idle_open;
   logic                         accept;
   logic                         coeff_wr;
   logic                         last_tap;
   logic signed [DataWidth-1:0]  mac_result;

   // Handshake qualification in IDLE.
   assign idle_open  = (state == IDLE) && !clearHistory;
   assign inReady    = idle_open;
   assign coeffReady = idle_open;
   assign accept     = idle_open && inValid;
   assign coeff_wr   = idle_open && coeffWrEn &&
                       ({1'b0, coeffAddr} < (PtrWidth + 1)'(NTaps));
   // Out-of-range channel tags fold onto channel 0.
   assign in_ch      = ({1'b0, inChannel} < (ChWidth + 1)'(NChannels)) ? inChannel : '0;
   assign last_tap   = (tap == PtrWidth'(NTaps - 1));

   // Tap k reads the sample written k accepts ago: (head - k) mod NTaps.
   assign hist_idx = (head[ch] >= tap) ? (head[ch] - tap)
                                       : (head[ch] + PtrWidth'(NTaps) - tap);
   assign prod     = ProdWidth'(coeff[tap]) * ProdWidth'(hist[ch][hist_idx]);
   assign acc_sum  = acc + AccWidth'(prod);

   fir_round_sat #(
      .AccWidth  (AccWidth),
      .DataWidth (DataWidth),
      .OutShift  (OutShift)
   ) u_round_sat (
      .acc    (acc_sum),
      .result (mac_result)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = bypass ? OUT : MAC;
         MAC:     if (last_tap) state_next = OUT;
         OUT:     if (outReady) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: coefficients, histories, accumulator and output register.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         for (int t = 0; t < NTaps; t++) coeff[t] <= '0;
         for (int c = 0; c < NChannels; c++) begin
            head[c] <= '0;
            for (int t = 0; t < NTaps; t++) hist[c][t] <= '0;
         end
         tap        <= '0;
         ch         <= '0;
         acc        <= '0;
         outValid   <= 1'b0;
         outData    <= '0;
         outChannel <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clearHistory) begin
                  for (int c = 0; c < NChannels; c++) begin
                     head[c] <= '0;
                     for (int t = 0; t < NTaps; t++) hist[c][t] <= '0;
                  end
               end else begin
                  if (coeff_wr) coeff[coeffAddr] <= coeffData;
                  if (inValid) begin
                     ch  <= in_ch;
                     tap <= '0;
                     acc <= '0;
                     if (bypass) begin
                        outValid   <= 1'b1;
                        outData    <= inData;
                        outChannel <= in_ch;
                     end else begin
                        hist[in_ch][head[in_ch]] <= inData;
                     end
                  end
               end
            end
            MAC: begin
               acc <= acc_sum;
               tap <= tap + PtrWidth'(1);
               if (last_tap) begin
                  head[ch]   <= (head[ch] == PtrWidth'(NTaps - 1)) ? '0
                                                                   : head[ch] + PtrWidth'(1);
                  outValid   <= 1'b1;
                  outData    <= mac_result;
                  outChannel <= ch;
               end
            end
            OUT: begin
               if (outReady) outValid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: two instances share all inputs,
// one with OutShift=0 and one with OutShift=1 for the rounding checks.
module tb_fir_mac_engine;

   logic              clk;
   logic              resetN;
   logic              coeffWrEn;
   logic [3:0]        coeffAddr;
   logic signed [7:0] coeffData;
   logic              clearHistory;
   logic              bypass;
   logic              inValid;
   logic signed [7:0] inData;
   logic [0:0]        inChannel;
   logic              outReady;

   logic              coeffReady,   coeffReady_r;
   logic              inReady,      inReady_r;
   logic              outValid,     outValid_r;
   logic signed [7:0] outData,      outData_r;
   logic [0:0]        outChannel,   outChannel_r;

   int total = 0;
   int bad   = 0;
   bit chk_r = 0;
   int q_data[$];
   int q_ch[$];
   int q_r[$];

   fir_mac_engine #(.NTaps(13), .DataWidth(8), .CoeffWidth(8), .NChannels(2), .OutShift(0)) dut (
      .clk(clk), .resetN(resetN),
      .coeffWrEn(coeffWrEn), .coeffAddr(coeffAddr), .coeffData(coeffData), .coeffReady(coeffReady),
      .clearHistory(clearHistory), .bypass(bypass),
      .inValid(inValid), .inReady(inReady), .inData(inData), .inChannel(inChannel),
      .outValid(outValid), .outReady(outReady), .outData(outData), .outChannel(outChannel)
   );

   fir_mac_engine #(.NTaps(13), .DataWidth(8), .CoeffWidth(8), .NChannels(2), .OutShift(1)) dut_r (
      .clk(clk), .resetN(resetN),
      .coeffWrEn(coeffWrEn), .coeffAddr(coeffAddr), .coeffData(coeffData), .coeffReady(coeffReady_r),
      .clearHistory(clearHistory), .bypass(bypass),
      .inValid(inValid), .inReady(inReady_r), .inData(inData), .inChannel(inChannel),
      .outValid(outValid_r), .outReady(outReady), .outData(outData_r), .outChannel(outChannel_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic write_coeff(input int addr, input int val);
      @(negedge clk);
      coeffWrEn = 1'b1;
      coeffAddr = 4'(addr);
      coeffData = 8'(val);
      @(negedge clk);
      coeffWrEn = 1'b0;
   endtask

   task automatic clear_hist(input bit with_valid);
      @(negedge clk);
      clearHistory = 1'b1;
      inValid      = with_valid;
      inData       = 8'sd100;
      inChannel    = 1'b0;
      #1;
      total++;
      if (inReady !== 1'b0 || coeffReady !== 1'b0) begin
         bad++;
         $display("FAIL clear_ready: inReady=%b coeffReady=%b required 0 0", inReady, coeffReady);
      end
      @(negedge clk);
      clearHistory = 1'b0;
      inValid      = 1'b0;
   endtask

   // Drive one sample, wait for its result, optionally stall, then release.
   task automatic send(input int ch, input int data, input bit byp,
                       input int exp0, input int expr, input int stall);
      int lat;
      bit seen;
      logic [7:0] e_data, e_r, hold;
      logic [0:0] e_ch;
      @(negedge clk);
      inValid   = 1'b1;
      inData    = 8'(data);
      inChannel = 1'(ch);
      bypass    = byp;
      outReady  = (stall == 0);
      q_data.push_back(exp0);
      q_ch.push_back(ch);
      q_r.push_back(expr);
      total++;
      if (inReady !== 1'b1) begin
         bad++;
         $display("FAIL in_ready_idle: got %b required 1", inReady);
      end
      lat  = 0;
      seen = 0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         inValid = 1'b0;
         bypass  = 1'b0;
         lat++;
         if (outValid === 1'b1) seen = 1;
      end
      e_data = 8'(q_data.pop_front());
      e_ch   = 1'(q_ch.pop_front());
      e_r    = 8'(q_r.pop_front());
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL out_timeout: outValid never rose within 40 cycles (ch=%0d data=%0d)", ch, data);
         outReady = 1'b1;
         repeat (3) @(negedge clk);
         return;
      end
      if (lat != (byp ? 1 : 14)) begin
         bad++;
         $display("FAIL latency: got %0d cycles required %0d", lat, byp ? 1 : 14);
      end
      total++;
      if (outData !== e_data || outChannel !== e_ch) begin
         bad++;
         $display("FAIL out_data: got data=%0d ch=%0d required data=%0d ch=%0d",
                  outData, outChannel, $signed(e_data), e_ch);
      end
      if (chk_r) begin
         total++;
         if (outValid_r !== 1'b1 || outData_r !== e_r) begin
            bad++;
            $display("FAIL round_data: got valid=%b data=%0d required valid=1 data=%0d",
                     outValid_r, outData_r, $signed(e_r));
         end
      end
      hold = outData;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         total++;
         if (outValid !== 1'b1 || outData !== hold || inReady !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold: got valid=%b data=%0d inReady=%b required 1 %0d 0",
                     outValid, outData, inReady, $signed(hold));
         end
      end
      outReady = 1'b1;
      @(negedge clk);
      total++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
         bad++;
         $display("FAIL release: got outValid=%b inReady=%b required 0 1", outValid, inReady);
      end
   endtask

   task automatic set_ramp_coeffs();
      for (int k = 0; k < 13; k++) write_coeff(k, k + 1);
   endtask

   task automatic test_reset();
      resetN = 1'b0; coeffWrEn = 1'b0; coeffAddr = '0; coeffData = '0;
      clearHistory = 1'b0; bypass = 1'b0; inValid = 1'b0; inData = '0;
      inChannel = '0; outReady = 1'b1;
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      total++;
      if (outValid !== 1'b0 || outData !== 8'sd0 || outChannel !== 1'b0) begin
         bad++;
         $display("FAIL reset_out: got valid=%b data=%0d ch=%0d required 0 0 0", outValid, outData, outChannel);
      end
      total++;
      if (inReady !== 1'b1 || coeffReady !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got inReady=%b coeffReady=%b required 1 1", inReady, coeffReady);
      end
   endtask

   task automatic test_impulse();
      set_ramp_coeffs();
      send(0, 1, 0, 1, 0, 0);
      for (int i = 1; i < 13; i++) send(0, 0, 0, i + 1, 0, 0);
      send(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_channels();
      clear_hist(0);
      for (int i = 0; i < 13; i++) begin
         send(0, (i == 0) ? 1 : 0, 0, i + 1, 0, 0);
         send(1, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic test_handshake();
      clear_hist(0);
      send(0, -37, 1, -37, 0, 5);
      send(0, 1, 0, 1, 0, 0);
      send(0, 0, 0, 2, 0, 5);
   endtask

   task automatic test_saturation();
      clear_hist(0);
      for (int k = 0; k < 13; k++) write_coeff(k, 127);
      for (int i = 0; i < 13; i++) send(1, 127, 0, 127, 0, 0);
      clear_hist(0);
      for (int i = 0; i < 13; i++) send(1, -128, 0, -128, 0, 0);
   endtask

   task automatic test_rounding();
      write_coeff(0, 3);
      for (int k = 1; k < 13; k++) write_coeff(k, 0);
      clear_hist(0);
      chk_r = 1;
      send(0, 1, 0, 3, 2, 0);
      send(0, -1, 0, -3, -1, 0);
      send(0, 0, 0, 0, 0, 0);
      chk_r = 0;
   endtask

   task automatic test_clear();
      bit rose;
      set_ramp_coeffs();
      // ch0 holds 1,-1,0 at slots 0..2 with head at 3.
      send(0, 5, 0, 6, 0, 0);
      clear_hist(1);
      rose = 0;
      repeat (20) begin
         @(negedge clk);
         if (outValid !== 1'b0) rose = 1;
      end
      total++;
      if (rose) begin
         bad++;
         $display("FAIL clear_no_accept: outValid rose=%b required 0", rose);
      end
      for (int i = 0; i < 13; i++) send(0, (i == 0) ? 1 : 0, 0, i + 1, 0, 0);
   endtask

   task automatic test_reset_mid_mac();
      bit rose;
      @(negedge clk);
      inValid = 1'b1; inData = 8'sd1; inChannel = 1'b0; bypass = 1'b0;
      @(negedge clk);
      inValid = 1'b0;
      repeat (6) @(negedge clk);
      resetN = 1'b0;
      @(negedge clk);
      resetN = 1'b1;
      rose = 0;
      repeat (30) begin
         @(negedge clk);
         if (outValid !== 1'b0) rose = 1;
      end
      total++;
      if (rose) begin
         bad++;
         $display("FAIL reset_abort: outValid rose=%b required 0", rose);
      end
      send(0, 1, 0, 0, 0, 0);
      send(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_channels();
      test_handshake();
      test_saturation();
      test_rounding();
      test_clear();
      test_reset_mid_mac();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
